sprite_loader: RTL
==================

# sprite_loader

Write-side companion to the on-chip 50×50×24-bit sprite RAMs. Accepts either an 8-bit RGB byte stream with a valid/ready handshake or a constant fill colour. Drives the RAM write port (`we`, `write_address`, data) to load or clear one full sprite image, then pulses `done`. It sits between the host/boot byte source and the sprite RAM's write port, one instance per RAM or muxed across RAMs by the caller.

## Interface
- `SPRITE_W`, 50: sprite width in pixels
- `SPRITE_H`, 50: sprite height in pixels
- `ADDR_W`, 19: RAM address width
- `DATA_W`, 24: pixel width, fixed as 3 bytes {R,G,B}
- `Clk`  in  1  sole clock, rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request; sampled only in IDLE
- `fill_en`  in  1  sampled with `start`: 1 = fill mode, 0 = stream mode
- `fill_color`  in  24  constant pixel for fill mode; sampled with `start`
- `abort`  in  1  cancels any operation
- `byte_data`  in  8  stream byte
- `byte_valid`  in  1  source has a byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  RAM write enable
- `write_address`  out  ADDR_W  RAM word address
- `wr_data`  out  24  RAM write data
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- N = SPRITE_W*SPRITE_H = 2500 words. Addresses are 0..N-1, written strictly ascending, each exactly once.
- States: IDLE, STREAM, FILL, FINISH.
- IDLE: `start` && !`abort` latches `fill_en`/`fill_color`, clears the word and byte counters, then goes to FILL or STREAM.
- STREAM: `byte_ready`=1. A byte is accepted on an edge where `byte_valid`&&`byte_ready`.
  - Bytes pack R→[23:16], G→[15:8], B→[7:0].
  - The 3rd accepted byte produces one write.
  - After the write of word N-1 is issued, `byte_ready` drops and the state goes to FINISH.
- FILL: one write per cycle of `fill_color` at addresses 0..N-1. After word N-1, go to FINISH.
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- `abort`, in any state, has highest priority. Next state is IDLE, partial bytes are discarded, no `done`, and no further `we`. Words already written stay written.
- `start` outside IDLE is ignored. `start`+`abort` in the same IDLE cycle: stay IDLE.
- `byte_valid` outside STREAM is ignored; `byte_ready`=0 there.
- The word counter is ceil(log2 N) bits; `write_address` is that counter zero-extended to ADDR_W. It never reaches N.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, packer cleared. Reset asserted mid-operation aborts immediately, with no `done`.
- All outputs are registered. `byte_ready` is a function of registered state only.
- `start` at cycle t gives `busy`=1 from t+1.
  - Stream mode: `byte_ready`=1 from t+1.
  - Fill mode: `we`=1 from t+1 at address 0.
- Stream write latency: `we`/`write_address`/`wr_data` are valid in the cycle after the edge accepting the 3rd byte. Peak rate is 1 word per 3 cycles. Gaps in `byte_valid` stall without loss.
- Fill: writes at cycles t+1..t+2500 (address = cycle−t−1), `done`=1 at t+2501, `busy`=0 from t+2502.
- Stream: `done`=1 in the cycle after the final `we`. `busy` is high through the `done` cycle and low the cycle after.
- `abort` at cycle a: `we`, `byte_ready`, `busy` are all 0 from a+1.

## Structure
- Package `sprite_pkg` holds:
  - constants `SPRITE_W`, `SPRITE_H`, `SPRITE_WORDS`, `ADDR_W`, `DATA_W`
  - typedef `loader_state_t` (IDLE, STREAM, FILL, FINISH)
  - typedef `pixel_t` (24-bit packed struct r/g/b)
- Sub-module `rgb_byte_packer`: 2-bit byte counter plus 16-bit holding register. Inputs: accept strobe, byte, clear. Outputs: word-complete strobe and the 24-bit word. The FSM, word counter and write-port registers stay in `sprite_loader`.

## Test plan
- Fill: `start`, `fill_en`=1, `fill_color`=24'hFF00FF. Expect 2500 consecutive `we` cycles at addresses 0..2499 with data FF00FF, then `done` exactly once, with no gaps or repeats.
- Stream back-to-back: bytes 12,34,56,AB,CD,EF,… Expect word 0 = 24'h123456 and word 1 = 24'hABCDEF. `we` follows each 3rd byte by 1 cycle. 7500 bytes give `done` and a reference-model compare of all RAM contents.
- Random `byte_valid` gaps (30% idle). Expect identical RAM contents to the back-to-back run, no byte dropped or duplicated, and `byte_ready`=0 after the 7500th byte.
- `abort` after 4 bytes (one word written, one byte pending). Expect exactly 1 `we`, no `done`, `busy`=0 next cycle. A following full stream starts again at address 0 with a fresh byte phase.
- `start` during FILL at word 100 is ignored (addresses stay contiguous). `start`+`abort` together in IDLE leaves `busy`=0.
- `Reset` asserted asynchronously mid-stream (between edges). Outputs go 0 immediately, no `done`, and a subsequent `start` works from address 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite RAM write-side loader.
package sprite_pkg;

    localparam int unsigned SPRITE_W     = 50;
    localparam int unsigned SPRITE_H     = 50;
    localparam int unsigned SPRITE_WORDS = SPRITE_W * SPRITE_H;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned DATA_W       = 24;
    localparam int unsigned CNT_W        = $clog2(SPRITE_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FILL,
        FINISH
    } loader_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/rgb_byte_packer.sv
// Gathers three accepted bytes (R, G, B) into one pixel word.
module rgb_byte_packer
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clear,
    input  logic       accept,
    input  logic [7:0] byte_data,
    output logic       word_done_c,
    output pixel_t     word_c
);

    logic [1:0]  byte_cnt;
    logic [15:0] hold;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            byte_cnt <= 2'd0;
            hold     <= 16'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            hold     <= 16'd0;
        end else if (accept) begin
            byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
            hold     <= {hold[7:0], byte_data};
        end
    end

    // The third byte completes the word in the same cycle it is accepted.
    assign word_done_c = accept && !clear && (byte_cnt == 2'd2);
    assign word_c      = {hold, byte_data};

endmodule

// File: rtl/sprite_loader.sv
// Loads or clears one full sprite image through the RAM write port.
module sprite_loader
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              abort,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(SPRITE_WORDS - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] word_cnt;
    pixel_t           fill_px;
    logic             pack_clear_c;
    logic             pack_accept_c;
    logic             word_done_c;
    pixel_t           word_c;

    assign pack_accept_c = byte_valid && byte_ready;
    assign pack_clear_c  = abort || (state != STREAM);

    rgb_byte_packer u_packer (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (pack_clear_c),
        .accept     (pack_accept_c),
        .byte_data  (byte_data),
        .word_done_c(word_done_c),
        .word_c     (word_c)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            word_cnt      <= '0;
            fill_px       <= '0;
            byte_ready    <= 1'b0;
            we            <= 1'b0;
            write_address <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                byte_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy     <= 1'b1;
                            word_cnt <= '0;
                            fill_px  <= fill_color;
                            if (fill_en) begin
                                state         <= FILL;
                                we            <= 1'b1;
                                write_address <= '0;
                                wr_data       <= fill_color;
                            end else begin
                                state      <= STREAM;
                                byte_ready <= 1'b1;
                            end
                        end
                    end
                    FILL: begin
                        if (word_cnt == LAST_WORD) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            word_cnt      <= word_cnt + CNT_W'(1);
                            we            <= 1'b1;
                            write_address <= ADDR_W'(word_cnt + CNT_W'(1));
                            wr_data       <= fill_px;
                        end
                    end
                    STREAM: begin
                        // byte_ready low here means the last word went out last cycle.
                        if (!byte_ready) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (word_done_c) begin
                            we            <= 1'b1;
                            write_address <= ADDR_W'(word_cnt);
                            wr_data       <= word_c;
                            if (word_cnt == LAST_WORD) begin
                                byte_ready <= 1'b0;
                            end else begin
                                word_cnt <= word_cnt + CNT_W'(1);
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
